// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: streams a tile of weight rows from the weight memory
// into a first-word-fall-through FIFO for the weight control unit.
// A read is issued only while the FIFO has room for it, so the FIFO can
// never overflow. Read data is pushed exactly one cycle after its issue.
// Optional feature: define WEIGHT_FETCH_PERF_EN to enable the saturating
// credit-stall counter on perf_stall_cycles_o. Otherwise the output is 0.
module weight_fetch_unit #(
  parameter int MUL_SIZE   = 32,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [7:0]                 u_dim_i,
  input  logic [7:0]                 iter_dim_i,
  input  logic [ADDR_W-1:0]          w_base_addr_i,
  output logic                       mem_rd_en_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [MUL_SIZE*DATA_W-1:0] mem_rd_data_i,
  input  logic                       fifo_rd_en_i,
  output logic                       fifo_valid_o,
  output logic [MUL_SIZE*DATA_W-1:0] fifo_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                perf_stall_cycles_o
);

  localparam int ROW_W    = MUL_SIZE * DATA_W;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int LOG2_MUL = $clog2(MUL_SIZE);

  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [15:0]       total_q;
  logic [15:0]       issued_q;
  logic [ADDR_W-1:0] base_q;
  logic              pend_q;
  logic              done_q;

  logic [CNT_W-1:0]  occ_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [ROW_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic [15:0]       u_tiles;
  logic [15:0]       i_tiles;
  logic [15:0]       start_rows;
  logic [CNT_W:0]    committed;
  logic              credit_ok;
  logic              start_acc;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;

  // Row count of the requested tile set: one MUL_SIZE-row tile per (u, iter) tile pair.
  assign u_tiles    = 16'(u_dim_i >> LOG2_MUL);
  assign i_tiles    = 16'(iter_dim_i >> LOG2_MUL);
  assign start_rows = u_tiles * i_tiles * 16'(MUL_SIZE);

  // Rows already stored plus the row whose data arrives next cycle must leave a free slot.
  assign committed  = {1'b0, occ_q} + {{CNT_W{1'b0}}, pend_q};
  assign credit_ok  = committed < DEPTH_C;

  assign start_acc  = (state_q == S_IDLE) && start_i;
  assign issue      = (state_q == S_FETCH) && credit_ok;
  assign last_issue = issue && (issued_q == total_q - 16'd1);
  assign push       = pend_q;
  assign pop        = fifo_rd_en_i && (occ_q != '0);

  // Next-state logic of the fetch sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && (start_rows != 16'd0)) state_d = S_FETCH;
      S_FETCH: if (last_issue) state_d = S_WAIT;
      S_WAIT:  if (pend_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, latched command, issue counter and in-flight flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      total_q  <= '0;
      issued_q <= '0;
      base_q   <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= issue;
      done_q  <= (start_acc && (start_rows == 16'd0)) || ((state_q == S_WAIT) && pend_q);
      if (start_acc) begin
        total_q  <= start_rows;
        base_q   <= w_base_addr_i;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 16'd1;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CNT_ONE;
        2'b01:   occ_q <= occ_q - CNT_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage; the credit check guarantees a push never lands on a full FIFO.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rd_data_i;
  end

`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0] perf_q;

  // Count FETCH cycles in which the FIFO credit check holds back the next read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if ((state_q == S_FETCH) && !credit_ok && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_q;
`else
  assign perf_stall_cycles_o = 32'd0;
`endif

  assign mem_rd_en_o  = issue;
  assign mem_addr_o   = issue ? (base_q + ADDR_W'(issued_q)) : '0;
  assign fifo_valid_o = (occ_q != '0);
  assign fifo_data_o  = fifo_valid_o ? fifo_mem[rd_ptr_q] : '0;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// tb_weight_fetch_unit: randomized scoreboard bench for weight_fetch_unit.
// The expected address/row stream of each command is queued when issued;
// a monitor pops and compares on every read strobe and every FIFO pop.
module tb_weight_fetch_unit;

  localparam int MUL_SIZE   = 32;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int ROW_W      = MUL_SIZE * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [7:0]        u_dim_i;
  logic [7:0]        iter_dim_i;
  logic [ADDR_W-1:0] w_base_addr_i;
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [ROW_W-1:0]  mem_rd_data_i;
  logic              fifo_rd_en_i;
  logic              fifo_valid_o;
  logic [ROW_W-1:0]  fifo_data_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       perf_stall_cycles_o;

  weight_fetch_unit #(
    .MUL_SIZE(MUL_SIZE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .u_dim_i(u_dim_i),
    .iter_dim_i(iter_dim_i), .w_base_addr_i(w_base_addr_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .fifo_rd_en_i(fifo_rd_en_i), .fifo_valid_o(fifo_valid_o), .fifo_data_o(fifo_data_o),
    .busy_o(busy_o), .done_o(done_o), .perf_stall_cycles_o(perf_stall_cycles_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_pct = 0;
  int run_reads = 0, run_total = 0, reads_tot = 0, pops_tot = 0;
  int done_cnt = 0, last_done_cyc = -1, start_cyc = 0;
  int first_rd_cyc = -1, last_rd_cyc = -1, first_valid_cyc = -1;
  int stall_exp = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [ROW_W-1:0]  exp_data[$];

  logic              cap_en = 1'b0;
  logic [ADDR_W-1:0] cap_addr = '0;

  // Content of a weight memory row, a fixed function of its address.
  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = {a, 16'(k * 4097)} ^ 32'hC3A5_0F96;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data for a read strobed in one cycle is presented during the next.
  always @(negedge clk) begin
    cap_en   = mem_rd_en_o;
    cap_addr = mem_addr_o;
  end
  always @(posedge clk) begin
    #1;
    if (cap_en) mem_rd_data_i = row_of(cap_addr);
    else        mem_rd_data_i = {8{$urandom}};
  end

  // Pop request generator.
  always @(posedge clk) begin
    #1;
    fifo_rd_en_i = ($urandom_range(0, 99) < pop_pct);
  end

  // Monitor: checks every read address and every popped row against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en_o) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read addr=%h (cycle %0d)", mem_addr_o, cyc);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = exp_addr.pop_front();
          if (mem_addr_o !== ea) begin
            errors++;
            $display("FAIL read_addr got=%h expected=%h (cycle %0d)", mem_addr_o, ea, cyc);
          end
        end
        checks++;
        if (reads_tot - pops_tot >= FIFO_DEPTH) begin
          errors++;
          $display("FAIL fifo_credit outstanding=%0d expected<%0d", reads_tot - pops_tot, FIFO_DEPTH);
        end
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        run_reads++;
        reads_tot++;
      end else if (busy_o && run_reads < run_total) begin
        stall_exp++;
      end
      if (fifo_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (fifo_valid_o && fifo_rd_en_i) begin
        pops_tot++;
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop data=%h", fifo_data_o);
        end else begin
          logic [ROW_W-1:0] ed;
          ed = exp_data.pop_front();
          if (fifo_data_o !== ed) begin
            errors++;
            $display("FAIL fifo_data got=%h expected=%h", fifo_data_o, ed);
          end
        end
      end
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  // One fetch command: queue expectations, start, optionally hold pops off, wait done, drain.
  task automatic run(input logic [7:0] u, input logic [7:0] it, input logic [ADDR_W-1:0] base,
                     input int pct, input int hold, input bit poke);
    int rows, t, d0, exp_perf;
    bit was_empty;
    rows = (int'(u) / 32) * (int'(it) / 32) * MUL_SIZE;
    for (int i = 0; i < rows; i++) begin
      exp_addr.push_back(base + ADDR_W'(i));
      exp_data.push_back(row_of(base + ADDR_W'(i)));
    end
    run_total = rows; run_reads = 0; stall_exp = 0;
    first_rd_cyc = -1; first_valid_cyc = -1;
    pop_pct = (hold > 0) ? 0 : pct;
    @(posedge clk); #1;
    was_empty = !fifo_valid_o;
    u_dim_i = u; iter_dim_i = it; w_base_addr_i = base; start_i = 1'b1;
    start_cyc = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b0; u_dim_i = 8'($urandom); iter_dim_i = 8'($urandom); w_base_addr_i = 16'($urandom);
    if (poke && busy_o) begin
      start_i = 1'b1; u_dim_i = 8'd96; iter_dim_i = 8'd96; w_base_addr_i = 16'h7777;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("hold_reads", run_reads, (rows < FIFO_DEPTH) ? rows : FIFO_DEPTH);
      chk("hold_valid", fifo_valid_o, (rows > 0) ? 1 : 0);
      chk("hold_busy", busy_o, (rows > FIFO_DEPTH) ? 1 : 0);
      pop_pct = pct;
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    chk("done_seen", (done_cnt != d0) ? 1 : 0, 1);
    chk("busy_after_done", busy_o, 0);
    chk("read_count", run_reads, rows);
    if (rows == 0) begin
      chk("zero_done_latency", last_done_cyc, start_cyc + 1);
    end else if (was_empty) begin
      chk("first_read_latency", first_rd_cyc, start_cyc + 1);
      chk("valid_latency", first_valid_cyc, first_rd_cyc + 2);
      if (pct == 100 && hold == 0) chk("throughput", last_rd_cyc - first_rd_cyc, rows - 1);
    end
`ifdef WEIGHT_FETCH_PERF_EN
    exp_perf = stall_exp;
`else
    exp_perf = 0;
`endif
    chk("perf_stall", perf_stall_cycles_o, exp_perf);
    pop_pct = 100;
    t = 0;
    while ((exp_data.size() != 0 || fifo_valid_o) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drained", exp_data.size(), 0);
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("valid_after_drain", fifo_valid_o, 0);
    chk("done_pulses", done_cnt - d0, 1);
    $display("run u=%0d iter=%0d base=%h pops=%0d%% hold=%0d poke=%0d rows=%0d reads=%0d",
             u, it, base, pct, hold, poke, rows, run_reads);
  endtask

  // Reset asserted while reads are still in flight.
  task automatic reset_mid();
    int t, bad;
    for (int i = 0; i < 128; i++) begin
      exp_addr.push_back(16'h3000 + ADDR_W'(i));
      exp_data.push_back(row_of(16'h3000 + ADDR_W'(i)));
    end
    run_total = 128; run_reads = 0; pop_pct = 0;
    @(posedge clk); #1;
    u_dim_i = 8'd64; iter_dim_i = 8'd64; w_base_addr_i = 16'h3000; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    t = 0;
    while (run_reads < 3 && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("reads_before_reset", run_reads, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_fifo_valid", fifo_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_en", mem_rd_en_o, 0);
    chk("rst_fifo_data", (fifo_data_o == '0) ? 1 : 0, 1);
    exp_addr.delete(); exp_data.delete();
    run_reads = 0; run_total = 0; reads_tot = 0; pops_tot = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (fifo_valid_o || mem_rd_en_o || busy_o) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    $display("reset mid-fetch: post-release active cycles=%0d", bad);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; u_dim_i = '0; iter_dim_i = '0; w_base_addr_i = '0;
    fifo_rd_en_i = 1'b0; mem_rd_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_en", mem_rd_en_o, 0);
    chk("reset_addr", mem_addr_o, 0);
    chk("reset_valid", fifo_valid_o, 0);
    chk("reset_data_zero", (fifo_data_o == '0) ? 1 : 0, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_perf", perf_stall_cycles_o, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(8'd32, 8'd32, 16'h0100, 100, 0, 1'b0);
    run(8'd64, 8'd64, 16'h2000, 100, 100, 1'b0);
    run(8'd0,  8'd32, 16'h1234, 100, 0, 1'b0);
    run(8'd32, 8'd32, 16'hFFF0, 100, 0, 1'b0);
    run(8'd32, 8'd32, 16'h4000, 100, 100, 1'b0);
    run(8'd32, 8'd64, 16'h0800, 70, 0, 1'b1);
    reset_mid();
    run(8'd32, 8'd32, 16'h0100, 100, 0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      run(8'(32 * $urandom_range(0, 3)), 8'(32 * $urandom_range(0, 3)), 16'($urandom),
          $urandom_range(20, 100), ($urandom_range(0, 3) == 0) ? 100 : 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
